seq_compare: RTL and testbench

SEQ_COMPARE -- requirements
Module: seq_compare

---
 rtl/seq_compare.sv | 131 +++++++++++++
 tb/tb_seq_compare.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_compare.sv
// Serial magnitude comparator: walks two latched 32-bit operands STEP bits per cycle, MSB chunk
// first, and stops at the first differing chunk.
module seq_compare #(
    parameter int STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sgn,
    output logic        busy,
    output logic        done,
    output logic        c1,
    output logic        c0
);

    localparam int N  = 32 / STEP;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    logic [1:0]      r_state;
    logic [31:0]     r_a;
    logic [31:0]     r_b;
    logic            r_sgn;
    logic [IW-1:0]   r_idx;
    logic            r_c1;
    logic            r_c0;

    logic [1:0]      w_state_nxt;
    logic [31:0]     w_a_nxt;
    logic [31:0]     w_b_nxt;
    logic            w_sgn_nxt;
    logic [IW-1:0]   w_idx_nxt;
    logic            w_c1_nxt;
    logic            w_c0_nxt;

    logic [31:0]     w_a_ord;
    logic [31:0]     w_b_ord;
    logic [4:0]      w_shamt;
    logic [STEP-1:0] w_a_chunk;
    logic [STEP-1:0] w_b_chunk;
    logic            w_lt;
    logic            w_gt;

    // Flipping the sign bits maps two's-complement order onto unsigned order.
    assign w_a_ord   = {r_a[31] ^ r_sgn, r_a[30:0]};
    assign w_b_ord   = {r_b[31] ^ r_sgn, r_b[30:0]};
    assign w_shamt   = 5'(r_idx) * 5'(STEP);
    assign w_a_chunk = STEP'(w_a_ord >> w_shamt);
    assign w_b_chunk = STEP'(w_b_ord >> w_shamt);
    assign w_lt      = (w_a_chunk < w_b_chunk);
    assign w_gt      = (w_a_chunk > w_b_chunk);

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_sgn_nxt   = r_sgn;
        w_idx_nxt   = r_idx;
        w_c1_nxt    = r_c1;
        w_c0_nxt    = r_c0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_a_nxt     = a;
                    w_b_nxt     = b;
                    w_sgn_nxt   = sgn;
                    w_idx_nxt   = IDX_TOP;
                    w_c1_nxt    = 1'b0;
                    w_c0_nxt    = 1'b0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_lt) begin
                    w_state_nxt = S_DONE;
                    w_c1_nxt    = 1'b1;
                    w_c0_nxt    = 1'b0;
                end else if (w_gt) begin
                    w_state_nxt = S_DONE;
                    w_c1_nxt    = 1'b0;
                    w_c0_nxt    = 1'b1;
                end else if (r_idx == '0) begin
                    w_state_nxt = S_DONE;
                    w_c1_nxt    = 1'b1;
                    w_c0_nxt    = 1'b1;
                end else begin
                    w_idx_nxt = r_idx - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sgn   <= 1'b0;
            r_idx   <= IDX_TOP;
            r_c1    <= 1'b0;
            r_c0    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_sgn   <= w_sgn_nxt;
            r_idx   <= w_idx_nxt;
            r_c1    <= w_c1_nxt;
            r_c0    <= w_c0_nxt;
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign c1   = r_c1;
    assign c0   = r_c0;

endmodule

// File: tb/tb_seq_compare.sv
// Bench for seq_compare: STEP=1/4/8 instances side by side, table vectors, directed sequences
// and a random sweep against an arithmetic reference model.
module tb_seq_compare;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [2:0]  c1_v;
    logic [2:0]  c0_v;

    always #5 clk = ~clk;

    seq_compare #(.STEP(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sgn(sgn),
        .busy(busy_v[0]), .done(done_v[0]), .c1(c1_v[0]), .c0(c0_v[0])
    );
    seq_compare #(.STEP(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sgn(sgn),
        .busy(busy_v[1]), .done(done_v[1]), .c1(c1_v[1]), .c0(c0_v[1])
    );
    seq_compare #(.STEP(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sgn(sgn),
        .busy(busy_v[2]), .done(done_v[2]), .c1(c1_v[2]), .c0(c0_v[2])
    );

    int checks   = 0;
    int failures = 0;
    int steps[3] = '{1, 4, 8};

    int         m_cyc[3];
    int         m_busy[3];
    int         m_pulses[3];
    logic [1:0] m_code[3];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [1:0]  code;
        int          cyc;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] exp_code(input logic [31:0] pa, input logic [31:0] pb,
                                            input logic ps);
        logic less;
        if (pa == pb) return 2'b11;
        less = ps ? ($signed(pa) < $signed(pb)) : (pa < pb);
        return less ? 2'b10 : 2'b01;
    endfunction

    // Cycle of the done pulse, counting the start-sampling cycle as cycle 0.
    function automatic int exp_cycle(input logic [31:0] pa, input logic [31:0] pb,
                                     input logic ps, input int step);
        logic [31:0] diff;
        diff = (pa ^ pb);
        if (diff == 0) return 32 / step + 1;
        for (int i = 31; i >= 0; i--) begin
            if (diff[i]) return (31 - i) / step + 2;
        end
        return 0;
    endfunction

    // Starts one compare on all instances and records each done cycle, code, busy and pulses.
    task automatic run_cmp(input logic [31:0] pa, input logic [31:0] pb, input logic ps);
        bit all_seen;
        for (int k = 0; k < 3; k++) begin
            m_cyc[k] = 0; m_busy[k] = 0; m_pulses[k] = 0; m_code[k] = 2'b00;
        end
        start = 1'b1; a = pa; b = pb; sgn = ps;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            a = $urandom; b = $urandom; sgn = 1'($urandom_range(0, 1));
            all_seen = 1'b1;
            for (int k = 0; k < 3; k++) begin
                if (busy_v[k]) m_busy[k]++;
                if (done_v[k]) begin
                    m_pulses[k]++;
                    if (m_cyc[k] == 0) begin
                        m_cyc[k]  = cyc;
                        m_code[k] = {c1_v[k], c0_v[k]};
                    end
                end
                if (m_cyc[k] == 0 || m_cyc[k] == cyc) all_seen = 1'b0;
            end
            if (all_seen) break;
        end
    endtask

    task automatic verify(input int k, input string tag, input logic [31:0] pa,
                          input logic [31:0] pb, input logic ps);
        int ec;
        ec = exp_cycle(pa ^ {ps, 31'b0}, pb ^ {ps, 31'b0}, 1'b0, steps[k]);
        check($sformatf("%s s%0d code a=%h b=%h sgn=%0d", tag, steps[k], pa, pb, ps),
              32'(m_code[k]), 32'(exp_code(pa, pb, ps)));
        check($sformatf("%s s%0d done_cycle a=%h b=%h", tag, steps[k], pa, pb),
              m_cyc[k], ec);
        check($sformatf("%s s%0d busy_cycles", tag, steps[k]), m_busy[k], ec - 1);
        check($sformatf("%s s%0d done_pulses", tag, steps[k]), m_pulses[k], 1);
    endtask

    initial begin
        logic [31:0] pa, pb;
        logic        ps;
        int          pulses;
        bit          exp_busy, exp_done;

        tbl[0] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 2'b01, 2};
        tbl[1] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 2'b10, 2};
        tbl[2] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 2'b11, 9};
        tbl[3] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 2'b10, 9};
        tbl[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 2'b10, 2};
        tbl[5] = '{32'h0010_0000, 32'h0020_0000, 1'b0, 2'b10, 4};
        tbl[6] = '{32'h8000_0001, 32'h8000_0000, 1'b1, 2'b01, 9};
        tbl[7] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 2'b11, 9};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; sgn = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        check("reset busy", 32'(busy_v), 32'h0);
        check("reset done", 32'(done_v), 32'h0);
        check("reset c1", 32'(c1_v), 32'h0);
        check("reset c0", 32'(c0_v), 32'h0);
        start = 1'b0;
        rst   = 1'b0;
        @(posedge clk); #1;
        check("idle after reset busy", 32'(busy_v), 32'h0);

        for (int t = 0; t < 8; t++) begin
            run_cmp(tbl[t].a, tbl[t].b, tbl[t].sgn);
            check($sformatf("tbl%0d code", t), 32'(m_code[1]), 32'(tbl[t].code));
            check($sformatf("tbl%0d done_cycle", t), m_cyc[1], tbl[t].cyc);
            check($sformatf("tbl%0d busy_cycles", t), m_busy[1], tbl[t].cyc - 1);
            check($sformatf("tbl%0d done_pulses", t), m_pulses[1], 1);
            verify(0, $sformatf("tbl%0d", t), tbl[t].a, tbl[t].b, tbl[t].sgn);
            verify(2, $sformatf("tbl%0d", t), tbl[t].a, tbl[t].b, tbl[t].sgn);
        end

        // Back-to-back with start held high; operand churn during RUN must be ignored.
        start = 1'b1; a = 32'd1; b = 32'd2; sgn = 1'b0;
        for (int cyc = 1; cyc <= 19; cyc++) begin
            @(posedge clk); #1;
            exp_busy = (cyc >= 1 && cyc <= 8) || (cyc >= 10 && cyc <= 17);
            exp_done = (cyc == 9) || (cyc == 18);
            check($sformatf("b2b busy cyc%0d", cyc), 32'(busy_v[1]), 32'(exp_busy));
            check($sformatf("b2b done cyc%0d", cyc), 32'(done_v[1]), 32'(exp_done));
            if (cyc == 9) begin
                check("b2b first code", 32'({c1_v[1], c0_v[1]}), 32'h2);
                a = 32'd3; b = 32'd3;
            end else if (cyc == 18) begin
                check("b2b second code", 32'({c1_v[1], c0_v[1]}), 32'h3);
                start = 1'b0;
            end else if (cyc == 19) begin
                check("b2b code held", 32'({c1_v[1], c0_v[1]}), 32'h3);
            end else begin
                a = $urandom; b = $urandom;
            end
        end

        // Asynchronous reset clears a held result between clock edges.
        #2 rst = 1'b1;
        #1 check("async rst clears held code", 32'({c1_v[1], c0_v[1]}), 32'h0);
        start = 1'b1;
        @(posedge clk); #1;
        check("start ignored in reset", 32'(busy_v), 32'h0);
        start = 1'b0;
        rst   = 1'b0;

        // Reset in cycle 4 of an equal-operand compare.
        start = 1'b1; a = 32'hCAFE_F00D; b = 32'hCAFE_F00D; sgn = 1'b0;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            a = $urandom; b = $urandom;
        end
        check("midrun busy before rst", 32'(busy_v[1]), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("midrun rst busy", 32'(busy_v[1]), 32'h0);
        check("midrun rst done", 32'(done_v[1]), 32'h0);
        check("midrun rst code", 32'({c1_v[1], c0_v[1]}), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(posedge clk); #1;
            if (done_v[1]) pulses++;
        end
        check("midrun no done pulse", pulses, 0);
        run_cmp(32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);
        for (int k = 0; k < 3; k++) verify(k, "post_rst", 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            pa = $urandom;
            case ($urandom_range(0, 3))
                0:       pb = pa;
                1:       pb = pa ^ (32'd1 << $urandom_range(0, 31));
                default: pb = $urandom;
            endcase
            ps = 1'($urandom_range(0, 1));
            run_cmp(pa, pb, ps);
            for (int k = 0; k < 3; k++) verify(k, "sweep", pa, pb, ps);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
